// File: rtl/vic_regs.sv
// VIC-20 video chip register file ($9000-$900F): CPU write decode, readback,
// raster line counter, light pen and paddle capture, and static display decode.
module vic_regs #(
   parameter logic [7:0] RST_9000 = 8'h05,
   parameter logic [7:0] RST_9001 = 8'h19,
   parameter logic [7:0] RST_9002 = 8'h96,
   parameter logic [7:0] RST_9003 = 8'h2E,
   parameter logic [7:0] RST_9005 = 8'hF0,
   parameter logic [7:0] RST_900F = 8'h1B
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_cs,
   input  logic        cpu_we,
   input  logic [3:0]  cpu_addr,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   input  logic        vga_hs,
   input  logic        vga_vs,
   input  logic [9:0]  hpos,
   input  logic        lp_n,
   input  logic [7:0]  pot_x,
   input  logic [7:0]  pot_y,
   output logic [15:0] screen_addr,
   output logic [15:0] char_rom_addr,
   output logic [15:0] color_ram_addr,
   output logic [2:0]  border_color,
   output logic [3:0]  back_color,
   output logic        inverted,
   output logic        chars8x16,
   output logic [3:0]  aux_color,
   output logic [6:0]  xorigin,
   output logic [6:0]  yorigin,
   output logic [6:0]  rows,
   output logic [6:0]  cols,
   output logic [7:0]  voice0,
   output logic [7:0]  voice1,
   output logic [7:0]  voice2,
   output logic [7:0]  voice3,
   output logic [3:0]  volume,
   output logic [8:0]  raster
);

   logic [7:0] reg_9000, reg_9001, reg_9002, reg_9005, reg_900e, reg_900f;
   logic [6:0] reg_9003;
   logic [7:0] lp_x, lp_y, pad_x, pad_y;
   logic [9:0] line;
   logic       hs_d, vs_d, lp_d;
   logic       hs_fall, vs_fall, lp_fall;
   logic [7:0] rd_data;
   logic       unused_bits;

   // VIC nibble -> CPU address: top bit selects the low/high half of the map
   function automatic logic [15:0] map_nibble(input logic [3:0] v);
      return {~v[3], 2'b00, v[2:0], 10'd0};
   endfunction

   assign hs_fall = hs_d & ~vga_hs;
   assign vs_fall = vs_d & ~vga_vs;
   assign lp_fall = lp_d & ~lp_n;
   assign raster  = line[9:1];
   assign unused_bits = ^{hpos[1:0], line[0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         reg_9000 <= RST_9000;
         reg_9001 <= RST_9001;
         reg_9002 <= RST_9002;
         reg_9003 <= RST_9003[6:0];
         reg_9005 <= RST_9005;
         reg_900f <= RST_900F;
         reg_900e <= 8'h00;
         voice0   <= 8'h00;
         voice1   <= 8'h00;
         voice2   <= 8'h00;
         voice3   <= 8'h00;
         lp_x     <= 8'h00;
         lp_y     <= 8'h00;
         pad_x    <= 8'h00;
         pad_y    <= 8'h00;
         line     <= 10'd0;
         hs_d     <= 1'b1;
         vs_d     <= 1'b1;
         lp_d     <= 1'b1;
         cpu_dout <= 8'h00;
      end else begin
         if (cpu_cs && cpu_we) begin
            case (cpu_addr)
               4'h0:    reg_9000 <= cpu_din;
               4'h1:    reg_9001 <= cpu_din;
               4'h2:    reg_9002 <= cpu_din;
               4'h3:    reg_9003 <= cpu_din[6:0];
               4'h5:    reg_9005 <= cpu_din;
               4'hA:    voice0   <= cpu_din;
               4'hB:    voice1   <= cpu_din;
               4'hC:    voice2   <= cpu_din;
               4'hD:    voice3   <= cpu_din;
               4'hE:    reg_900e <= cpu_din;
               4'hF:    reg_900f <= cpu_din;
               default: ;
            endcase
         end
         if (cpu_cs && !cpu_we) begin
            cpu_dout <= rd_data;
         end
         hs_d <= vga_hs;
         vs_d <= vga_vs;
         lp_d <= lp_n;
         // vsync takes priority so a coincident hsync edge still starts at line 0
         if (vs_fall) begin
            line <= 10'd0;
         end else if (hs_fall && line != 10'd1023) begin
            line <= line + 10'd1;
         end
         if (lp_fall) begin
            lp_x <= hpos[9:2];
            lp_y <= raster[8:1];
         end
         pad_x <= pot_x;
         pad_y <= pot_y;
      end
   end

   always_comb begin
      rd_data = 8'h00;
      case (cpu_addr)
         4'h0:    rd_data = reg_9000;
         4'h1:    rd_data = reg_9001;
         4'h2:    rd_data = reg_9002;
         4'h3:    rd_data = {raster[0], reg_9003};
         4'h4:    rd_data = raster[8:1];
         4'h5:    rd_data = reg_9005;
         4'h6:    rd_data = lp_x;
         4'h7:    rd_data = lp_y;
         4'h8:    rd_data = pad_x;
         4'h9:    rd_data = pad_y;
         4'hA:    rd_data = voice0;
         4'hB:    rd_data = voice1;
         4'hC:    rd_data = voice2;
         4'hD:    rd_data = voice3;
         4'hE:    rd_data = reg_900e;
         4'hF:    rd_data = reg_900f;
         default: rd_data = 8'h00;
      endcase
   end

   assign xorigin        = reg_9000[6:0];
   assign yorigin        = reg_9001[6:0];
   assign cols           = reg_9002[6:0];
   assign rows           = {1'b0, reg_9003[6:1]};
   assign chars8x16      = reg_9003[0];
   assign screen_addr    = map_nibble(reg_9005[7:4]) | {6'd0, reg_9002[7], 9'd0};
   assign char_rom_addr  = map_nibble(reg_9005[3:0]);
   assign color_ram_addr = 16'h9400 | {6'd0, reg_9002[7], 9'd0};
   assign aux_color      = reg_900e[7:4];
   assign volume         = reg_900e[3:0];
   assign back_color     = reg_900f[7:4];
   assign inverted       = reg_900f[3];
   assign border_color   = reg_900f[2:0];

endmodule

// File: tb/tb_vic_regs.sv
// Scoreboard bench for vic_regs: stimulus queues expected values with a due
// cycle, a negedge monitor pops and compares them against the DUT outputs.
module tb_vic_regs;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_cs = 1'b0, cpu_we = 1'b0;
   logic [3:0]  cpu_addr = 4'h0;
   logic [7:0]  cpu_din = 8'h00;
   logic [7:0]  cpu_dout;
   logic        vga_hs = 1'b1, vga_vs = 1'b1, lp_n = 1'b1;
   logic [9:0]  hpos = 10'd0;
   logic [7:0]  pot_x = 8'h00, pot_y = 8'h00;
   logic [15:0] screen_addr, char_rom_addr, color_ram_addr;
   logic [2:0]  border_color;
   logic [3:0]  back_color, aux_color, volume;
   logic        inverted, chars8x16;
   logic [6:0]  xorigin, yorigin, rows, cols;
   logic [7:0]  voice0, voice1, voice2, voice3;
   logic [8:0]  raster;

   vic_regs dut (
      .clk(clk), .reset(reset), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .hpos(hpos), .lp_n(lp_n),
      .pot_x(pot_x), .pot_y(pot_y), .screen_addr(screen_addr),
      .char_rom_addr(char_rom_addr), .color_ram_addr(color_ram_addr),
      .border_color(border_color), .back_color(back_color),
      .inverted(inverted), .chars8x16(chars8x16), .aux_color(aux_color),
      .xorigin(xorigin), .yorigin(yorigin), .rows(rows), .cols(cols),
      .voice0(voice0), .voice1(voice1), .voice2(voice2), .voice3(voice3),
      .volume(volume), .raster(raster)
   );

   always #5 clk = ~clk;

   typedef enum int {K_SCREEN, K_CHAR, K_COLOR, K_COLS, K_ROWS, K_BACK, K_INV,
                     K_BORDER, K_C816, K_RASTER, K_DOUT, K_VOL, K_AUX} kind_t;
   typedef struct { kind_t kind; logic [15:0] exp; int due; } exp_t;

   exp_t sbq[$];
   exp_t cur;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] actual(input kind_t k);
      case (k)
         K_SCREEN: return screen_addr;
         K_CHAR:   return char_rom_addr;
         K_COLOR:  return color_ram_addr;
         K_COLS:   return {9'd0, cols};
         K_ROWS:   return {9'd0, rows};
         K_BACK:   return {12'd0, back_color};
         K_INV:    return {15'd0, inverted};
         K_BORDER: return {13'd0, border_color};
         K_C816:   return {15'd0, chars8x16};
         K_RASTER: return {7'd0, raster};
         K_DOUT:   return {8'd0, cpu_dout};
         K_VOL:    return {12'd0, volume};
         K_AUX:    return {12'd0, aux_color};
         default:  return 16'hDEAD;
      endcase
   endfunction

   // Monitor: compare every entry whose due cycle has arrived
   always @(negedge clk) begin
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
         cur = sbq.pop_front();
         checks++;
         if (actual(cur.kind) !== cur.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     cur.kind.name(), actual(cur.kind), cur.exp, cyc);
         end
      end
   end

   task automatic expect_val(input kind_t k, input logic [15:0] e, input int lat);
      sbq.push_back('{kind: k, exp: e, due: cyc + lat});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
      tick();
      cpu_cs = 1'b0; cpu_we = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, input logic [7:0] e);
      cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = a;
      expect_val(K_DOUT, {8'd0, e}, 1);
      tick();
      cpu_cs = 1'b0;
   endtask

   task automatic hs_pulse();
      vga_hs = 1'b0; tick();
      vga_hs = 1'b1; tick();
   endtask

   task automatic vs_pulse();
      vga_vs = 1'b0; tick();
      vga_vs = 1'b1; tick();
   endtask

   task automatic expect_defaults();
      expect_val(K_SCREEN, 16'h1E00, 0);
      expect_val(K_CHAR,   16'h8000, 0);
      expect_val(K_COLOR,  16'h9600, 0);
      expect_val(K_COLS,   16'd22, 0);
      expect_val(K_ROWS,   16'd23, 0);
      expect_val(K_BACK,   16'd1, 0);
      expect_val(K_INV,    16'd1, 0);
      expect_val(K_BORDER, 16'd3, 0);
      expect_val(K_C816,   16'd0, 0);
      expect_val(K_RASTER, 16'd0, 0);
      expect_val(K_DOUT,   16'd0, 0);
      expect_val(K_VOL,    16'd0, 0);
   endtask

   initial begin
      tick(); tick();
      reset = 1'b0;
      tick();
      expect_defaults();
      tick();

      // Base addresses
      wr(4'h5, 8'hCD);
      expect_val(K_SCREEN, 16'h1E00 & 16'h0000 | 16'h1200, 0);
      expect_val(K_CHAR,   16'h1400, 0);
      wr(4'h2, 8'h16);
      expect_val(K_SCREEN, 16'h1000, 0);
      expect_val(K_COLOR,  16'h9400, 0);
      expect_val(K_COLS,   16'd22, 0);
      tick();

      // Raster: some lines, then vsync clears, then 101 lines
      repeat (3) hs_pulse();
      expect_val(K_RASTER, 16'd1, 0);
      vs_pulse();
      expect_val(K_RASTER, 16'd0, 0);
      repeat (101) hs_pulse();
      expect_val(K_RASTER, 16'd50, 0);
      rd(4'h4, 8'h19);
      rd(4'h3, 8'h2E);

      // Read-only register ignores writes
      wr(4'h4, 8'hFF);
      rd(4'h4, 8'h19);

      // Light pen latch, then held low must not re-latch
      hpos = 10'h1A4; lp_n = 1'b0; tick();
      rd(4'h6, 8'h69);
      rd(4'h7, 8'h19);
      hpos = 10'h3FC;
      repeat (3) hs_pulse();
      expect_val(K_RASTER, 16'd52, 0);
      rd(4'h6, 8'h69);
      rd(4'h7, 8'h19);
      lp_n = 1'b1; tick();

      // $9003: bit 7 not stored, reads back raster[0]
      wr(4'h3, 8'hFF);
      expect_val(K_ROWS, 16'd63, 0);
      expect_val(K_C816, 16'd1, 0);
      rd(4'h3, 8'h7F);
      hs_pulse(); hs_pulse();
      expect_val(K_RASTER, 16'd53, 0);
      rd(4'h3, 8'hFF);

      // Coincident hsync/vsync: vsync wins
      vga_hs = 1'b0; vga_vs = 1'b0; tick();
      expect_val(K_RASTER, 16'd0, 0);
      vga_hs = 1'b1; vga_vs = 1'b1; tick();

      // Paddle capture
      pot_x = 8'h5A; pot_y = 8'hC3; tick();
      rd(4'h8, 8'h5A);
      rd(4'h9, 8'hC3);

      // Colours and sound, then mid-run reset
      wr(4'hF, 8'h62);
      expect_val(K_BACK,   16'd6, 0);
      expect_val(K_INV,    16'd0, 0);
      expect_val(K_BORDER, 16'd2, 0);
      wr(4'hE, 8'hA7);
      expect_val(K_VOL, 16'd7, 0);
      expect_val(K_AUX, 16'd10, 0);
      repeat (5) hs_pulse();
      tick();
      reset = 1'b1; tick();
      reset = 1'b0;
      expect_defaults();
      tick();

      for (int i = 0; i < 20 && sbq.size() > 0; i++) tick();
      if (sbq.size() > 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, 0 required", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vic_regs.md
Name: vic_regs

Overview:
- CPU-facing register file for the VIC-20 video chip, at $9000-$900F. It sits directly upstream of the VGA video generator.
- It decodes CPU writes into the static display configuration the generator consumes: screen, character and colour-RAM base addresses, colours, origin, rows and columns.
- It maintains a raster counter from the generator's sync outputs and serves CPU readback, including raster, light pen and paddle values.
- It also exports the sound registers for the audio block.

Parameters:
- RST_9000, 8'h05: reset value of $9000 (interlace bit, xorigin).
- RST_9001, 8'h19: reset value of $9001 (yorigin).
- RST_9002, 8'h96: reset value of $9002 (screen A9 bit, cols).
- RST_9003, 8'h2E: reset value of $9003 (rows, 8x16 bit); bit 7 ignored.
- RST_9005, 8'hF0: reset value of $9005 (screen and char base nibbles).
- RST_900F, 8'h1B: reset value of $900F (back, inverted, border).

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  synchronous, active-high
- cpu_cs  in  1  register select (external decode of $900x)
- cpu_we  in  1  write strobe, qualified by cpu_cs
- cpu_addr  in  4  register index
- cpu_din  in  8  write data
- cpu_dout  out  8  registered read data
- vga_hs  in  1  active-low hsync from video
- vga_vs  in  1  active-low vsync from video
- hpos  in  10  current video horizontal counter
- lp_n  in  1  light pen, active-low
- pot_x  in  8  paddle X
- pot_y  in  8  paddle Y
- screen_addr  out  16  CPU address of screen matrix
- char_rom_addr  out  16  CPU address of character generator
- color_ram_addr  out  16  CPU address of colour RAM
- border_color  out  3  border colour
- back_color  out  4  background colour
- inverted  out  1  pixel polarity
- chars8x16  out  1  double-height characters
- aux_color  out  4  multicolour auxiliary colour
- xorigin  out  7  horizontal origin
- yorigin  out  7  vertical origin
- rows  out  7  text rows
- cols  out  7  text columns
- voice0..voice3  out  8 each  registers $900A-$900D
- volume  out  4  $900E[3:0]
- raster  out  9  current raster line

Behaviour:
- Writes: when cpu_cs && cpu_we on a clk edge, the register indexed by cpu_addr updates on that edge; outputs reflect the new value in the following cycle.
- Read-only registers: writes to $9004, $9006, $9007, $9008 and $9009 are ignored.
- $9003 writes: only bits 6:0 are stored.
- Reads: when cpu_cs && !cpu_we, cpu_dout is loaded on that edge with the value sampled that cycle (1-cycle latency). Otherwise cpu_dout holds its last value.
  - $9003 reads as {raster[0], stored[6:0]}.
  - $9004 reads as raster[8:1].
- Decoded outputs (all combinational from stored registers):
  - xorigin = $9000[6:0]; yorigin = $9001[6:0].
  - cols = $9002[6:0]; rows = {1'b0, $9003[6:1]}; chars8x16 = $9003[0].
  - Address mapping: for nibble v, CPU address = {~v[3], 2'b00, v[2:0], 10'b0}.
  - screen_addr = map($9005[7:4]) | ($9002[7] << 9).
  - char_rom_addr = map($9005[3:0]).
  - color_ram_addr = 16'h9400 | ($9002[7] << 9).
  - aux_color = $900E[7:4]; volume = $900E[3:0].
  - back_color = $900F[7:4]; inverted = $900F[3]; border_color = $900F[2:0].
- Raster counter:
  - hs and vs are registered once for edge detection.
  - A falling edge of vs clears the 10-bit line counter to 0.
  - Otherwise, a falling edge of hs increments the line counter, saturating at 1023.
  - If both edges fall in the same cycle, vs wins and the counter becomes 0.
  - raster = line[9:1].
- Light pen: on a falling edge of lp_n, $9006 <= hpos[9:2] and $9007 <= raster[8:1]. Holding lp_n low does not re-latch.
- Paddles: $9008 <= pot_x and $9009 <= pot_y, registered every cycle.
- Reset (mid-operation included): all stored registers take their RST_* values. $9004 and $900A-$900E reset to 0. Line counter, light pen latches and cpu_dout reset to 0. Edge-detect registers reset to 1.
- Default decode after reset: screen 0x1E00, char 0x8000, colour 0x9600, cols 22, rows 23.

Test Plan:
- Reset, then idle -> screen_addr 0x1E00, char_rom_addr 0x8000, color_ram_addr 0x9600, cols 22, rows 23, back_color 1, inverted 1, border_color 3, chars8x16 0, raster 0.
- Write $9005=0xCD, $9002=0x16 -> screen_addr 0x1000, char_rom_addr 0x1400, color_ram_addr 0x9400, cols 22 (one cycle after each write).
- vs falling edge, then 101 hs falling edges -> raster 50. Read $9004 -> 0x19 next cycle; read $9003 -> bit7 = 0. Coincident hs/vs edge -> line 0.
- Write $9004=0xFF -> readback unchanged. Write $9003=0xFF -> rows 63, chars8x16 1, readback bit7 = raster[0].
- lp_n falls with hpos=0x1A4, raster=50 -> $9006 reads 0x69, $9007 reads 0x19. lp_n held low while hpos changes -> values unchanged.
- Write $900F=0x62, $900E=0xA7, then assert reset one cycle -> outputs return to reset defaults, cpu_dout 0, volume 0.
